// File: rtl/feature_frame_packer_pkg.sv
// Shared constants and types for the feature frame packer.
// Frame geometry (channels per frame, bits per channel, channels per beat)
// and the derived beat count / counter width live here so that every file
// of the packer agrees on them.
package feature_frame_packer_pkg;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int CHANNEL_WIDTH     = 2;
    localparam int TOTAL_NUM_CHANNEL = 214;
    localparam int BEAT_CHANNELS     = 8;
    localparam int NUM_BEATS         = ceil_div(TOTAL_NUM_CHANNEL, BEAT_CHANNELS);
    localparam int BEAT_CNT_WIDTH    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int BEAT_W            = BEAT_CHANNELS * CHANNEL_WIDTH;
    localparam int FRAME_W           = TOTAL_NUM_CHANNEL * CHANNEL_WIDTH;

    typedef enum logic {
        ASSEMBLE = 1'b0,
        DROP     = 1'b1
    } state_t;

endpackage

// File: rtl/feature_frame_packer_if.sv
// Handshake bundle between the sensor feature source, the packer and the
// hdc_sensor_fusion frame input.
//   s_valid/s_ready/s_data/s_last : narrow beat stream into the packer
//   fin_valid/fin_ready/features_top : assembled frame toward the consumer
// master : the environment side (drives beats and fin_ready)
// slave  : the packer side
interface feature_frame_packer_if
    import feature_frame_packer_pkg::*;
;
    logic               s_valid;
    logic               s_ready;
    logic [BEAT_W-1:0]  s_data;
    logic               s_last;
    logic               fin_valid;
    logic               fin_ready;
    logic [FRAME_W-1:0] features_top;

    modport master (
        output s_valid, s_data, s_last, fin_ready,
        input  s_ready, fin_valid, features_top
    );

    modport slave (
        input  s_valid, s_data, s_last, fin_ready,
        output s_ready, fin_valid, features_top
    );

endinterface

// File: rtl/feature_frame_packer_frame_output_buffer.sv
// Two-entry frame hold: the assembly register (owned by the top) plus the
// output register held here.
//   clk, rst      : clock, asynchronous active-low reset
//   complete      : final beat of a good frame is being accepted this cycle
//   frame_in      : assembly contents including any beat accepted this cycle
//   asm_full      : a completed frame is parked in the assembly register
//   fin_ready     : consumer accepts the presented frame
//   fin_valid     : output register holds a frame
//   features_top  : output register
module feature_frame_packer_frame_output_buffer
    import feature_frame_packer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               complete,
    input  logic [FRAME_W-1:0] frame_in,
    output logic               asm_full,
    input  logic               fin_ready,
    output logic               fin_valid,
    output logic [FRAME_W-1:0] features_top
);

    // The output slot can take a new frame on this edge if it is empty or
    // its current frame is being handed off on this same edge.
    logic out_free;
    assign out_free = !fin_valid || fin_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_full     <= 1'b0;
            fin_valid    <= 1'b0;
            features_top <= '0;
        end else if (asm_full) begin
            // No beats are accepted while parked, so frame_in is the held frame.
            if (out_free) begin
                features_top <= frame_in;
                fin_valid    <= 1'b1;
                asm_full     <= 1'b0;
            end
        end else if (complete) begin
            if (out_free) begin
                features_top <= frame_in;
                fin_valid    <= 1'b1;
            end else begin
                asm_full <= 1'b1;
            end
        end else if (fin_ready) begin
            fin_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/feature_frame_packer.sv
// Transmit-side front end for hdc_sensor_fusion. Collects narrow beats of
// quantised channel features into one full frame and presents it on
// features_top with a valid/ready handshake.
//   clk, rst     : clock, asynchronous active-low reset
//   bus          : beat input (s_*) and frame output (fin_*, features_top)
//   frame_err    : one-cycle pulse when a frame is discarded for bad framing
//   frame_count  : frames handed to the consumer, wraps at 16 bits
module feature_frame_packer
    import feature_frame_packer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    feature_frame_packer_if.slave  bus,
    output logic                   frame_err,
    output logic [15:0]            frame_count
);

    localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(NUM_BEATS - 1);

    state_t                    state, state_next;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt, beat_cnt_next;
    logic                      err_next;
    logic                      complete;
    logic                      accept;
    logic                      asm_full;
    logic [FRAME_W-1:0]        asm_reg, asm_next;

    // s_ready depends only on the registered park flag, never on fin_ready.
    assign bus.s_ready = !asm_full;
    assign accept      = bus.s_valid && !asm_full;

    // Lane placement: channel c lands at features_top[(TOTAL-1-c)*CW +: CW],
    // so channel 0 is in the MSBs. Lanes past the last channel are dropped.
    always_comb begin
        asm_next = asm_reg;
        if (accept && state == ASSEMBLE) begin
            for (int j = 0; j < BEAT_CHANNELS; j++) begin
                if (int'(beat_cnt) * BEAT_CHANNELS + j < TOTAL_NUM_CHANNEL) begin
                    asm_next[(TOTAL_NUM_CHANNEL - 1 - (int'(beat_cnt) * BEAT_CHANNELS + j))
                             * CHANNEL_WIDTH +: CHANNEL_WIDTH] =
                        bus.s_data[j * CHANNEL_WIDTH +: CHANNEL_WIDTH];
                end
            end
        end
    end

    // Assembly contents need no reset: every good frame overwrites every
    // channel before it is ever copied to the output register.
    always_ff @(posedge clk) begin
        asm_reg <= asm_next;
    end

    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        err_next      = 1'b0;
        complete      = 1'b0;
        unique case (state)
            ASSEMBLE: begin
                if (accept) begin
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt_next = '0;
                        if (bus.s_last) begin
                            complete = 1'b1;
                        end else begin
                            // Too many beats: discard the rest up to s_last.
                            err_next   = 1'b1;
                            state_next = DROP;
                        end
                    end else if (bus.s_last) begin
                        beat_cnt_next = '0;
                        err_next      = 1'b1;
                    end else begin
                        beat_cnt_next = beat_cnt + 1'b1;
                    end
                end
            end
            DROP: begin
                if (accept && bus.s_last) begin
                    state_next = ASSEMBLE;
                end
            end
            default: state_next = ASSEMBLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ASSEMBLE;
            beat_cnt    <= '0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            state     <= state_next;
            beat_cnt  <= beat_cnt_next;
            frame_err <= err_next;
            if (bus.fin_valid && bus.fin_ready) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    feature_frame_packer_frame_output_buffer u_buf (
        .clk          (clk),
        .rst          (rst),
        .complete     (complete),
        .frame_in     (asm_next),
        .asm_full     (asm_full),
        .fin_ready    (bus.fin_ready),
        .fin_valid    (bus.fin_valid),
        .features_top (bus.features_top)
    );

endmodule

// File: tb/tb_feature_frame_packer.sv
module tb_feature_frame_packer;
    import feature_frame_packer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_err;
    logic [15:0] frame_count;

    feature_frame_packer_if bus ();

    feature_frame_packer dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [FRAME_W-1:0] exp_q[$];
    int delivered    = 0;
    int err_seen     = 0;
    int err_exp      = 0;
    int stall_cycles = 0;
    int cyc          = 0;
    int hs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Channel value for pattern s; channels past the frame carry 3 so that
    // any leak of ignored lanes shows up.
    function automatic logic [1:0] pat(input int c, input int s);
        if (c >= TOTAL_NUM_CHANNEL) return 2'b11;
        return 2'((c + s * ((c / 3) + 1)) % 4);
    endfunction

    // Compare process: output frame, frame counter and error pulses.
    always @(negedge clk) begin
        checks++;
        if (frame_count !== 16'(delivered)) begin
            errors++;
            $display("FAIL frame_count actual=%0d required=%0d", frame_count, delivered);
        end
        if (frame_err === 1'b1) err_seen++;
        if (bus.fin_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fin_valid_unexpected actual=1 required=0");
            end else if (bus.features_top !== exp_q[0]) begin
                errors++;
                $display("FAIL features_top actual=%h required=%h", bus.features_top, exp_q[0]);
            end
            if (bus.fin_ready === 1'b1 && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                delivered++;
                hs_cyc.push_back(cyc);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat was taken.
    task automatic send_beat(input logic [BEAT_W-1:0] d, input logic l);
        int waited;
        waited      = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        @(negedge clk);
        while (bus.s_ready !== 1'b1 && waited < 500) begin
            waited++;
            stall_cycles++;
            @(negedge clk);
        end
        if (bus.s_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL s_ready_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    function automatic logic [BEAT_W-1:0] beat_data(input int k, input int s);
        logic [BEAT_W-1:0] d;
        d = '0;
        for (int j = 0; j < BEAT_CHANNELS; j++)
            d[j * CHANNEL_WIDTH +: CHANNEL_WIDTH] = pat(k * BEAT_CHANNELS + j, s);
        return d;
    endfunction

    // A frame is the run of beats up to s_last; only a run of exactly
    // NUM_BEATS beats is delivered, any other run costs one error pulse.
    task automatic send_frame(input int nbeats, input int s);
        logic [FRAME_W-1:0] exp;
        exp = '0;
        for (int c = 0; c < TOTAL_NUM_CHANNEL; c++)
            exp = (exp << CHANNEL_WIDTH) | FRAME_W'(pat(c, s));
        for (int k = 0; k < nbeats; k++)
            send_beat(beat_data(k, s), k == nbeats - 1);
        if (nbeats == NUM_BEATS) exp_q.push_back(exp);
        else err_exp++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset_now();
        rst = 1'b0;
        exp_q.delete();
        delivered = 0;
        #1;
        check("rst_fin_valid", bus.fin_valid, 1'b0);
        check("rst_features_nonzero", |bus.features_top, 1'b0);
        check("rst_frame_count", frame_count, 16'd0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_s_ready", bus.s_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int eb, fc, sc, h0;

    initial begin
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        bus.fin_ready = 1'b1;
        rst           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fin_valid", bus.fin_valid, 1'b0);
        check("rst_features_nonzero", |bus.features_top, 1'b0);
        check("rst_frame_count", frame_count, 16'd0);
        check("rst_s_ready", bus.s_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single frame, pattern c%4, latency and literal channel positions
        eb = err_seen;
        send_frame(NUM_BEATS, 0);
        check("t1_latency_fin_valid", bus.fin_valid, 1'b1);
        check("t1_ch0_msb", bus.features_top[427:426], 2'd0);
        check("t1_ch213_lsb", bus.features_top[1:0], 2'd1);
        check("t1_ch211", bus.features_top[5:4], 2'd3);
        check("t1_ch1", bus.features_top[425:424], 2'd1);
        idle(1);
        check("t1_frame_count", frame_count, 16'd1);
        check("t1_fin_valid_drop", bus.fin_valid, 1'b0);
        check("t1_no_err", err_seen - eb, 0);

        // Backpressure: A presented, B parked, then one fin_ready cycle
        bus.fin_ready = 1'b0;
        send_frame(NUM_BEATS, 1);
        send_frame(NUM_BEATS, 2);
        check("bp_s_ready_low", bus.s_ready, 1'b0);
        check("bp_fin_valid", bus.fin_valid, 1'b1);
        fc = int'(frame_count);
        idle(3);
        check("bp_s_ready_held", bus.s_ready, 1'b0);
        check("bp_fin_valid_held", bus.fin_valid, 1'b1);
        bus.fin_ready = 1'b1;
        idle(1);
        bus.fin_ready = 1'b0;
        check("bp_b_presented", bus.fin_valid, 1'b1);
        check("bp_s_ready_back", bus.s_ready, 1'b1);
        check("bp_count", int'(frame_count) - fc, 1);
        idle(2);
        bus.fin_ready = 1'b1;
        idle(2);

        // Early s_last on beat 10, then a good frame
        eb = err_seen;
        send_frame(11, 3);
        check("early_err_pulse", frame_err, 1'b1);
        idle(1);
        check("early_err_one_cycle", frame_err, 1'b0);
        send_frame(NUM_BEATS, 4);
        idle(2);
        check("early_err_count", err_seen - eb, 1);

        // Missing s_last: 30-beat run, then a good frame
        eb = err_seen;
        send_frame(NUM_BEATS + 3, 5);
        send_frame(NUM_BEATS, 6);
        idle(2);
        check("drop_err_count", err_seen - eb, 1);

        // Back-to-back throughput with fin_ready held high
        sc = stall_cycles;
        h0 = hs_cyc.size();
        fc = int'(frame_count);
        for (int i = 0; i < 4; i++) send_frame(NUM_BEATS, 7 + i);
        idle(2);
        check("tp_no_stall", stall_cycles - sc, 0);
        check("tp_count", 16'(int'(frame_count) - fc), 16'd4);
        check("tp_hs_num", hs_cyc.size() - h0, 4);
        for (int i = h0 + 1; i < hs_cyc.size(); i++)
            check("tp_spacing", hs_cyc[i] - hs_cyc[i - 1], NUM_BEATS);

        // Async reset at beat 15 of a frame
        for (int k = 0; k < 15; k++) send_beat(beat_data(k, 11), 1'b0);
        #2;
        apply_reset_now();
        send_frame(NUM_BEATS, 12);
        idle(2);
        check("rst1_recover_count", frame_count, 16'd1);

        // Async reset while a frame is parked
        bus.fin_ready = 1'b0;
        send_frame(NUM_BEATS, 13);
        send_frame(NUM_BEATS, 14);
        check("rst2_parked", bus.s_ready, 1'b0);
        #2;
        apply_reset_now();
        bus.fin_ready = 1'b1;
        send_frame(NUM_BEATS, 15);
        idle(2);
        check("rst2_recover_count", frame_count, 16'd1);

        check("err_total", err_seen, err_exp);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/feature_frame_packer.md
Name: feature_frame_packer

Overview:
- Transmit-side front end for hdc_sensor_fusion: drives its fin_valid/fin_ready/features_top input interface.
- Accepts the sensor feature stream as narrow beats of BEAT_CHANNELS 2-bit quantised channel features and assembles one full frame of TOTAL_NUM_CHANNEL features.
- Presents each assembled frame on features_top with valid/ready handshake; a second buffer lets the next frame assemble while the current one waits for fin_ready.

Parameters:
- TOTAL_NUM_CHANNEL, 214, channels per frame (GSR+ECG+EEG).
- CHANNEL_WIDTH, 2, bits per channel feature.
- BEAT_CHANNELS, 8, channels per input beat; NUM_BEATS = ceil(TOTAL_NUM_CHANNEL/BEAT_CHANNELS), 27 at defaults.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready.
- s_data  in  BEAT_CHANNELS*CHANNEL_WIDTH  lane j = s_data[j*CW +: CW].
- s_last  in  1  marks final beat of a frame.
- fin_valid  out  1  frame valid toward hdc_sensor_fusion.
- fin_ready  in  1  frame accepted by hdc_sensor_fusion.
- features_top  out  TOTAL_NUM_CHANNEL*CHANNEL_WIDTH  assembled frame.
- frame_err  out  1  one-cycle pulse on a framing error.
- frame_count  out  16  frames delivered (fin_valid & fin_ready), wraps 0xFFFF->0.

Behaviour:
- Reset (rst low, async): fin_valid=0, features_top=0, frame_err=0, frame_count=0, beat counter=0, state ASSEMBLE, asm_full=0, s_ready=1.
- Beat accepted on s_valid & s_ready.
- Lane mapping: beat k, lane j carries channel c = k*BEAT_CHANNELS+j.
  - Channel c is placed at features_top[(TOTAL_NUM_CHANNEL-1-c)*CW +: CW], so channel 0 sits in the MSBs.
  - Lanes with c >= TOTAL_NUM_CHANNEL (last beat only: lanes 6,7 at defaults) are ignored.
- States:
  - ASSEMBLE: counter increments per accepted beat.
    - s_last on beat < NUM_BEATS-1: frame discarded, frame_err pulses the next cycle, counter->0, stay ASSEMBLE.
    - Beat NUM_BEATS-1 with s_last: frame complete, counter->0.
    - Beat NUM_BEATS-1 without s_last: frame discarded, frame_err pulses, go to DROP.
  - DROP: accept and discard beats (s_ready=1) until a beat with s_last, then return to ASSEMBLE with counter=0. No further frame_err pulses inside DROP.
- Completion transfer:
  - If output register empty, or fin_valid & fin_ready in the same cycle: output loads on the same edge as the final beat. fin_valid=1 and features_top updated the cycle after final-beat acceptance (latency 1).
  - Otherwise asm_full=1, holding the frame; it moves to the output on the first edge where the output empties or fin_ready is high; asm_full then clears.
- s_ready = !asm_full (registered flag, no combinational path from fin_ready).
- fin_valid stays high and features_top stable until fin_ready; then fin_valid drops unless a new frame loads that edge.
- Throughput: one beat per cycle sustained; back-to-back frames produce no bubble on fin_valid when fin_ready is held high.
- Partial-frame bits never leak to features_top: the output register is written only on completion.
- Reset mid-frame: all state cleared; the partial frame and any held frame are lost.

Decomposition:
- Shared package (const.vh macros): CHANNEL_WIDTH, TOTAL_NUM_CHANNEL, BEAT_CHANNELS, NUM_BEATS, BEAT_CNT_WIDTH = clog2(NUM_BEATS); state enum {ASSEMBLE, DROP}.
- One sub-module, frame_output_buffer: the 2-entry (assembly + output) hold/skid logic with fin_valid/fin_ready.
- The top handles beat counting, lane placement and error FSM.

Test Plan:
- Single frame, defaults: 27 beats, beat k lane j = (k*8+j)%4, s_last on beat 26, fin_ready=1 -> fin_valid one cycle after beat 26; features_top[427:426]=0 (ch0), [1:0]=(213%4)=1; frame_count=1; frame_err never pulses.
- Backpressure: two frames streamed continuously, fin_ready=0 -> frame A on output, frame B completes, asm_full=1, s_ready=0. Raise fin_ready one cycle -> A accepted, B presented next cycle, s_ready returns 1; frame_count=1.
- Early s_last on beat 10 -> frame_err pulse 1 cycle, no fin_valid. The next full 27-beat frame is delivered correctly.
- Missing s_last on beat 26; 3 extra beats, s_last on the third -> one frame_err pulse, no fin_valid; the following good frame is delivered intact.
- Back-to-back throughput, fin_ready=1, 4 frames at s_valid=1 every cycle -> fin_valid pulses every 27 cycles, s_ready never deasserts, frame_count=4.
- Async reset asserted at beat 15 and while a frame is held -> fin_valid=0, features_top=0, frame_count=0 immediately. After release, a fresh 27-beat frame is delivered correctly.
